// File: rtl/nand_vector_sequencer.sv
// Stimulus sequencer for the three-stage NAND chain: walks {a,b,c,d} through all
// 16 combinations, either timed (auto) or one vector per step-button edge (manual).
module nand_vector_sequencer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step,
    input  logic       mode,
    input  logic       loop,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [3:0] vec_idx,
    output logic       valid,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state;
    logic [15:0] hold_cnt;
    logic        start_q;
    logic        step_q;
    logic        mode_q;
    logic        start_edge;
    logic        step_edge;
    logic        mode_changed;
    logic        advance;

    assign start_edge   = start & ~start_q;
    assign step_edge    = step & ~step_q;
    assign mode_changed = mode ^ mode_q;

    // The cycle in which mode flips only restarts the hold count; the new
    // mode governs advancing from the following cycle onwards.
    always_comb begin
        advance = 1'b0;
        if (!mode_changed) begin
            if (mode) begin
                advance = (hold_cnt == HOLD_LAST);
            end else begin
                advance = step_edge;
            end
        end
    end

    assign {a, b, c, d} = vec_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vec_idx  <= 4'd0;
            valid    <= 1'b0;
            done     <= 1'b0;
            hold_cnt <= 16'd0;
            start_q  <= 1'b1;
            step_q   <= 1'b1;
            mode_q   <= 1'b0;
        end else begin
            start_q <= start;
            step_q  <= step;
            mode_q  <= mode;
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state    <= RUN;
                        vec_idx  <= 4'd0;
                        hold_cnt <= 16'd0;
                        valid    <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (mode_changed) begin
                        hold_cnt <= 16'd0;
                    end else if (advance) begin
                        hold_cnt <= 16'd0;
                        if (vec_idx != 4'd15) begin
                            vec_idx <= vec_idx + 4'd1;
                        end else if (loop) begin
                            vec_idx <= 4'd0;
                        end else begin
                            // Last vector stays on the pins while DONE is shown.
                            state <= DONE;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (mode) begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end else begin
                        hold_cnt <= 16'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    vec_idx  <= 4'd0;
                    valid    <= 1'b0;
                    done     <= 1'b0;
                    hold_cnt <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/nand_vector_sequencer.md
# nand_vector_sequencer

Upstream stimulus stage for the three-stage NAND chain (inputs a, b, c, d; outputs e, f, g). Steps through all 16 combinations of {a,b,c,d} on registered outputs, either automatically with a fixed hold time per vector or manually on a step button. Provides a vector index, a valid flag and a done flag so a downstream checker or the board LEDs can track progress.

## Interface
- HOLD_CYCLES, default 4: clock cycles each vector is held in auto mode; legal range 1..2^16-1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high; forces IDLE immediately.
- start  in  1  level input; its rising edge starts a sweep.
- step  in  1  level input; its rising edge advances one vector in manual mode.
- mode  in  1  0 = manual (step-driven), 1 = auto (HOLD_CYCLES-timed).
- loop  in  1  1 = wrap from vector 15 to 0 and keep running; 0 = stop after vector 15.
- a  out  1  vec_idx[3].
- b  out  1  vec_idx[2].
- c  out  1  vec_idx[1].
- d  out  1  vec_idx[0].
- vec_idx  out  4  index of the vector currently on a..d.
- valid  out  1  high while a..d carry a vector of an active sweep.
- done  out  1  high in DONE; cleared by the next start edge or by reset.

## Operation
- All outputs registered. Outputs a..d are always equal to the bits of vec_idx.
- Edge detect: start_q and step_q are one-cycle delayed copies of the inputs. A rising edge means input = 1 and delayed copy = 0. Both delayed copies reset to 1, so a level held high through reset deassertion is not an edge.
- hold_cnt: 16-bit counter. Cleared on entry to RUN, on every vector advance and on any change of mode.
- IDLE:
  - vec_idx = 0, valid = 0, done = 0.
  - Start edge -> RUN with vec_idx = 0, hold_cnt = 0.
- RUN, valid = 1:
  - Auto: hold_cnt increments each cycle. When hold_cnt = HOLD_CYCLES-1, the vector advances and hold_cnt returns to 0. Step edges are ignored.
  - Manual: each step edge advances the vector; hold_cnt stays 0.
  - Advance from vec_idx < 15: vec_idx increments.
  - Advance from vec_idx = 15 with loop = 1: vec_idx = 0, stay in RUN.
  - Advance from vec_idx = 15 with loop = 0: go to DONE.
  - A start edge in RUN is ignored.
  - A mode change takes effect on the next cycle and does not change vec_idx.
- DONE:
  - valid = 0, done = 1, vec_idx holds 15 (a..d = 1111).
  - Start edge -> RUN at vec_idx = 0, done = 0, valid = 1.
  - Step edges are ignored.
- Reset at any time, mid-sweep included: immediately returns to IDLE values. No partial vector survives.

## Timing
- Reset values: a = b = c = d = 0, vec_idx = 0, valid = 0, done = 0, state = IDLE, hold_cnt = 0, start_q = step_q = 1.
- Start latency: start rises before edge k -> after edge k, state = RUN, valid = 1, vec_idx = 0.
- Auto mode: every vector is visible for exactly HOLD_CYCLES cycles. A non-looping sweep keeps valid high for 16*HOLD_CYCLES cycles. done rises on the edge at which valid falls.
- HOLD_CYCLES = 1: the vector changes every cycle.
- Manual mode: step rises before edge k -> vec_idx changes after edge k. A step held high advances only once.
- Both edges in the same cycle: in IDLE/DONE, start wins and step is ignored; in RUN, start is ignored and step applies (manual mode only).
- Combinational NAND outputs downstream settle within the same cycle. The sampling point is one cycle after a vector change.

## Test plan
- Reset, then start edge with mode = 1, loop = 0, HOLD_CYCLES = 4 -> vectors 0..15, each for exactly 4 cycles; valid high for 64 cycles; then done = 1, valid = 0, abcd = 1111.
- mode = 0: start, then 5 single-cycle step pulses -> vec_idx = 5, abcd = 0101. Step held high for 10 cycles -> vec_idx = 6 only.
- loop = 1, HOLD_CYCLES = 1 -> vec_idx goes 15 then 0 on consecutive cycles; done never asserts over 40 cycles.
- Assert rst mid-sweep at vec_idx = 9 -> outputs go to 0 / valid = 0 without waiting for a clock edge. start high through rst release -> no sweep begins until start falls and rises again.
- In DONE, start and step edges in the same cycle -> RUN at vec_idx = 0, done = 0. Start edge during RUN -> no restart, vec_idx continues.
- Mode toggled 1 -> 0 at vec_idx = 3 mid-hold -> vec_idx stays 3 until the next step edge; toggling back to 1 -> a full 4-cycle hold before advancing to 4.
